// File: rtl/c2_serial_decoder_pkg.sv
// Shared definitions for the two's-complement encoder/decoder pair.
package c2_serial_decoder_pkg;

    // Default word width for both directions of the conversion.
    localparam int C2_WIDTH = 5;

    // Controller state encodings, shared with the encoder.
    localparam logic [1:0] C2_IDLE  = 2'd0;
    localparam logic [1:0] C2_SHIFT = 2'd1;
    localparam logic [1:0] C2_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = C2_IDLE,
        ST_SHIFT = C2_SHIFT,
        ST_DONE  = C2_DONE
    } c2_state_e;

endpackage

// File: rtl/c2_serial_decoder_bit_cell.sv
// One bit of the serial two's-complement negation: copy bits up to and
// including the first 1, invert every bit after it. Positive words pass through.
module c2_bit_cell (
    input  logic b,
    input  logic sign,
    input  logic seen_one,
    output logic m,
    output logic seen_next
);

    // Invert only once a 1 has already been passed on a negative word.
    always_comb begin
        m         = (sign && seen_one) ? ~b : b;
        seen_next = seen_one | b;
    end

endmodule

// File: rtl/c2_serial_decoder.sv
// Bit-serial two's-complement to sign-magnitude decoder.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | in_ready high, waiting for a word
//   SHIFT | converting one bit per clock, LSB first, WIDTH clocks total
//   DONE  | result held on out_* with out_valid high until out_ready
module c2_serial_decoder
    import c2_serial_decoder_pkg::*;
#(
    parameter int WIDTH = C2_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    c2_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             m;
    logic             seen_next;

    c2_bit_cell u_bit_cell (
        .b         (shreg_q[0]),
        .sign      (sign_q),
        .seen_one  (seen_q),
        .m         (m),
        .seen_next (seen_next)
    );

    // Next-state and datapath update for the accept / shift / hold sequence.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    sign_d  = in_data[WIDTH-1];
                    mag_d   = '0;
                    ovf_d   = 1'b0;
                    seen_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = shreg_q >> 1;
                mag_d   = {m, mag_q[WIDTH-1:1]};
                seen_d  = seen_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Most negative word: all lower bits were 0 and the MSB is 1.
                    ovf_d   = sign_q & ~seen_q & shreg_q[0];
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    // Output decode.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = valid_q;
        out_sign  = sign_q;
        out_mag   = mag_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_c2_serial_decoder.sv
// Testbench for c2_serial_decoder (WIDTH=5).
module tb_c2_serial_decoder;

    localparam int W = 5;

    typedef struct {
        logic         sign;
        logic [W-1:0] mag;
        logic         ovf;
        int           val;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_mag;
    logic         out_ovf;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    c2_serial_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: arithmetic value of the word, independent of the serial algorithm.
    function automatic exp_t model(input logic [W-1:0] d);
        exp_t e;
        int   v;
        v = int'($signed(d));
        e.val  = v;
        e.sign = (v < 0);
        e.mag  = W'((v < 0) ? -v : v);
        e.ovf  = (v == -(1 << (W - 1)));
        return e;
    endfunction

    // Push one word through the DUT, optionally stalling and pulsing in_valid while busy.
    task automatic do_word(input logic [W-1:0] d, input int stall, input bit pulse_valid);
        exp_t e;
        int   lat;
        int   recon;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        else n_pass++;
        in_data  = d;
        in_valid = 1'b1;
        sb.push_back(model(d));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 3 * W) begin
            if (pulse_valid) in_valid = ~in_valid;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        n_total++;
        if (lat !== W) $display("FAIL latency d=%b: got %0d edges required %0d", d, lat, W);
        else n_pass++;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty: size 0 required >0");
            return;
        end
        e = sb.pop_front();
        n_total++;
        if (out_sign !== e.sign) $display("FAIL sign d=%b: got %b required %b", d, out_sign, e.sign);
        else n_pass++;
        n_total++;
        if (out_mag !== e.mag) $display("FAIL mag d=%b: got %b required %b", d, out_mag, e.mag);
        else n_pass++;
        n_total++;
        if (out_ovf !== e.ovf) $display("FAIL ovf d=%b: got %b required %b", d, out_ovf, e.ovf);
        else n_pass++;
        recon = out_sign ? -int'(out_mag) : int'(out_mag);
        n_total++;
        if (recon !== e.val) $display("FAIL roundtrip d=%b: got %0d required %0d", d, recon, e.val);
        else n_pass++;
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            if (pulse_valid) in_valid = 1'b1;
            @(posedge clk); #1;
            n_total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sign !== e.sign
                || out_mag !== e.mag || out_ovf !== e.ovf)
                $display("FAIL hold d=%b cyc%0d: valid=%b ready=%b sign=%b mag=%b ovf=%b required 1 0 %b %b %b",
                         d, s, out_valid, in_ready, out_sign, out_mag, out_ovf, e.sign, e.mag, e.ovf);
            else n_pass++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL release d=%b: valid=%b in_ready=%b required 0 1", d, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sign !== 1'b0
            || out_mag !== '0 || out_ovf !== 1'b0)
            $display("FAIL reset_state: rdy=%b val=%b sign=%b mag=%b ovf=%b required 1 0 0 00000 0",
                     in_ready, out_valid, out_sign, out_mag, out_ovf);
        else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL after_reset: rdy=%b val=%b required 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_values();
        logic [W-1:0] vec [6];
        vec[0] = 5'b00111;
        vec[1] = 5'b11001;
        vec[2] = 5'b11111;
        vec[3] = 5'b10110;
        vec[4] = 5'b10000;
        vec[5] = 5'b00000;
        foreach (vec[i]) do_word(vec[i], 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_word(5'b10001, 3, 1'b1);
    endtask

    task automatic test_reset_mid();
        int seen_valid;
        in_data  = 5'b11011;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sign !== 1'b0
            || out_mag !== '0 || out_ovf !== 1'b0)
            $display("FAIL async_reset: rdy=%b val=%b sign=%b mag=%b ovf=%b required 1 0 0 00000 0",
                     in_ready, out_valid, out_sign, out_mag, out_ovf);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        seen_valid = 0;
        for (int c = 0; c < 2 * W; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen_valid++;
        end
        n_total++;
        if (seen_valid !== 0 || in_ready !== 1'b1)
            $display("FAIL reset_discard: valid_cycles=%0d in_ready=%b required 0 1", seen_valid, in_ready);
        else n_pass++;
        do_word(5'b01010, 0, 1'b0);
    endtask

    task automatic test_exhaustive();
        for (int i = 0; i < (1 << W); i++)
            do_word(W'(i), int'($urandom_range(0, 3)), 1'b0);
    endtask

    task automatic test_back_to_back();
        do_word(5'b01111, 0, 1'b0);
        do_word(5'b10000, 0, 1'b0);
        do_word(5'b00001, 1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_values();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
